// File: rtl/sensor_fault_handler.sv
// Purpose : debounces the sensor detector's error line, latches the sensor snapshot on a qualified fault,
//           holds a sticky fault flag until the host acknowledges it, and keeps a saturating fault count.
// Latency : error first sampled high at edge k and held -> fault visible after edge k+DEBOUNCE-1.
// Backpressure: none; ack is the only handshake, and it is honoured only while a fault is pending.
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   error         - raw error line from the detector, sampled every edge
//   sensors[3:0]  - sensor vector, captured into fault_code at qualification
//   ack           - host acknowledge (pulse or level)
//   clr_count     - synchronous clear of fault_count (wins over a coincident capture)
//   fault         - sticky qualified-fault flag
//   fault_code    - sensors value captured at the last qualification
//   fault_count   - saturating count of qualified faults
//   busy          - high whenever the handler is not idle
module sensor_fault_handler #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             error,
  input  logic [3:0]       sensors,
  input  logic             ack,
  input  logic             clr_count,
  output logic             fault,
  output logic [3:0]       fault_code,
  output logic [CNT_W-1:0] fault_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    QUALIFY    = 2'd1,
    FAULT      = 2'd2,
    WAIT_CLEAR = 2'd3
  } state_t;

  // Counter value at which the next high sample completes qualification.
  localparam logic [3:0]       DB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [3:0]       code_q, code_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    count_d = count_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (error) begin
          if (DEBOUNCE == 1) begin
            state_d = FAULT;
            capture = 1'b1;
          end else begin
            state_d = QUALIFY;
            cnt_d   = 4'd1;
          end
        end
      end
      QUALIFY: begin
        if (!error) begin
          // A glitch shorter than DEBOUNCE leaves no trace.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == DB_LAST) begin
          state_d = FAULT;
          cnt_d   = 4'd0;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FAULT: begin
        // A still-active error parks in WAIT_CLEAR so it is not counted twice.
        if (ack) begin
          state_d = error ? WAIT_CLEAR : IDLE;
        end
      end
      WAIT_CLEAR: begin
        if (!error) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (capture) begin
      code_d = sensors;
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_W'(1);
      end
    end

    // Clear overrides a coincident capture increment; the snapshot still updates.
    if (clr_count) begin
      count_d = '0;
    end

    fault_d = (state_d == FAULT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      fault_q <= 1'b0;
      code_q  <= 4'd0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_count = count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sensor_fault_handler.sv
module tb_sensor_fault_handler;

  localparam int DB    = 3;
  localparam int CW    = 4;
  localparam int C_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          error = 1'b0;
  logic [3:0]    sensors = 4'd0;
  logic          ack = 1'b0;
  logic          clr_count = 1'b0;
  logic          fault;
  logic [3:0]    fault_code;
  logic [CW-1:0] fault_count;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  sensor_fault_handler #(.DEBOUNCE(DB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .error(error), .sensors(sensors), .ack(ack),
    .clr_count(clr_count), .fault(fault), .fault_code(fault_code),
    .fault_count(fault_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the length of the current high run of error,
  // whether a fault is pending, and whether a persistent error is being waited out.
  int m_run   = 0;
  bit m_fault = 1'b0;
  bit m_hold  = 1'b0;
  int m_code  = 0;
  int m_count = 0;
  bit m_busy  = 1'b0;

  always @(posedge clk) begin
    bit cap;
    cap = 1'b0;
    if (rst) begin
      m_run = 0; m_fault = 0; m_hold = 0; m_code = 0; m_count = 0;
    end else begin
      if (m_fault) begin
        if (ack) begin
          m_fault = 0;
          m_hold  = error;
        end
      end else if (m_hold) begin
        if (!error) m_hold = 0;
      end else if (error) begin
        m_run = m_run + 1;
        if (m_run >= DB) begin
          cap = 1'b1; m_run = 0; m_fault = 1;
        end
      end else begin
        m_run = 0;
      end
      if (cap) begin
        m_code = sensors;
        if (m_count < C_MAX) m_count = m_count + 1;
      end
      if (clr_count) m_count = 0;
    end
    m_busy = m_fault || m_hold || (m_run > 0);
  end

  // Compare process: outputs are checked against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec = n_vec + 1;
      if (fault !== m_fault || fault_code !== 4'(m_code) ||
          fault_count !== CW'(m_count) || busy !== m_busy) begin
        n_bad = n_bad + 1;
        $display("FAIL model t=%0t: fault=%b/%b code=%h/%h count=%0d/%0d busy=%b/%b (dut/model)",
                 $time, fault, m_fault, fault_code, 4'(m_code), fault_count, m_count, busy, m_busy);
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int f, input int c, input int n, input int b);
    chk({name, ".fault"}, int'(fault), f);
    chk({name, ".code"},  int'(fault_code), c);
    chk({name, ".count"}, int'(fault_count), n);
    chk({name, ".busy"},  int'(busy), b);
  endtask

  // One full qualified fault with sensors=s, acknowledged with error low.
  task automatic one_fault(input logic [3:0] s);
    sensors = s; error = 1'b1; ack = 1'b0;
    cyc(DB);
    error = 1'b0; ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  initial begin
    // 1. Reset with error and sensors active.
    rst = 1'b1; error = 1'b1; sensors = 4'b1111;
    cyc(2);
    chk_en = 1'b1;
    chk_all("reset", 0, 0, 0, 0);

    // 2. Glitch of two high samples.
    rst = 1'b0; sensors = 4'b0001;
    cyc(1);
    chk_all("glitch1", 0, 0, 0, 1);
    cyc(1);
    chk_all("glitch2", 0, 0, 0, 1);
    error = 1'b0;
    cyc(1);
    chk_all("glitch_end", 0, 0, 0, 0);

    // 3. Qualified fault, acknowledged with error low.
    sensors = 4'b1010; error = 1'b1;
    cyc(2);
    chk("q3_pre.fault", int'(fault), 0);
    cyc(1);
    chk_all("q3", 1, 4'b1010, 1, 1);
    error = 1'b0; ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk_all("q3_ack", 0, 4'b1010, 1, 0);

    // 4. Persistent error through qualification and ack.
    error = 1'b1;
    cyc(3);
    chk_all("p4_fault", 1, 4'b1010, 2, 1);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk_all("p4_wait", 0, 4'b1010, 2, 1);
    cyc(10);
    chk_all("p4_wait10", 0, 4'b1010, 2, 1);
    error = 1'b0;
    cyc(1);
    chk("p4_idle.busy", int'(busy), 0);
    sensors = 4'b0110; error = 1'b1;
    cyc(3);
    chk_all("p4_refault", 1, 4'b0110, 3, 1);
    error = 1'b0; ack = 1'b1;
    cyc(1);
    ack = 1'b0;

    // 5. Saturation: 3 + 12 = 15, then further faults hold at 15.
    for (int i = 0; i < 12; i++) one_fault(4'(i));
    chk("sat15.count", int'(fault_count), 15);
    one_fault(4'b1100);
    chk("sat16.count", int'(fault_count), 15);
    chk("sat16.code", int'(fault_code), 4'b1100);
    one_fault(4'b0011);
    chk("sat17.count", int'(fault_count), 15);

    // Clear on the capture edge wins over the increment.
    sensors = 4'b0101; error = 1'b1;
    cyc(2);
    clr_count = 1'b1;
    cyc(1);
    clr_count = 1'b0;
    chk_all("clr_cap", 1, 4'b0101, 0, 1);
    error = 1'b0; ack = 1'b1;
    cyc(1);

    // ack held through IDLE and QUALIFY has no effect.
    cyc(2);
    chk_all("ack_idle", 0, 4'b0101, 0, 0);
    error = 1'b1;
    cyc(2);
    chk_all("ack_qual", 0, 4'b0101, 0, 1);
    error = 1'b0;
    cyc(1);
    ack = 1'b0;
    chk_all("ack_qual_end", 0, 4'b0101, 0, 0);

    // 6. Reset while in FAULT with code 1010 and count 3.
    one_fault(4'b1010);
    one_fault(4'b1010);
    sensors = 4'b1010; error = 1'b1;
    cyc(3);
    chk_all("r6_pre", 1, 4'b1010, 3, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_all("r6_rst", 0, 0, 0, 0);
    cyc(2);
    chk_all("r6_two", 0, 0, 0, 1);
    cyc(1);
    chk_all("r6_three", 1, 4'b1010, 1, 1);
    error = 1'b0; ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
